adc_acq_controller: RTL and testbench
=====================================

// Module: adc_acq_controller
// PURPOSE
//  Sequences one ADC capture run into PSRAM. Enables adc_module, discards warm-up strobes, then packs each adc_ready sample into a 16-bit word.
//  Words are buffered in a small FIFO and issued to the PSRAM controller as fixed-length write bursts at incrementing addresses.
//  Sits between adc_module (upstream) and the PSRAM write port (downstream). Runs entirely in the clk_PSRAM domain.
// PARAMETERS
//  BURST_WORDS  8   words per PSRAM write burst; power of two, >=2
//  FIFO_DEPTH   16  sample FIFO depth; power of two, >= 2*BURST_WORDS
//  ADDR_W       21  PSRAM word-address width
//  DISCARD      2   adc_ready strobes dropped after enable, before capture
// PORTS
//  clk_PSRAM      in   1       system clock; all logic on rising edge
//  rst_n          in   1       synchronous reset, active-low
//  start          in   1       1-cycle pulse: begin run (ignored while busy)
//  stop           in   1       1-cycle pulse: abort capture early
//  base_addr      in   ADDR_W  first burst address, latched at start
//  num_bursts     in   16      bursts to capture, latched at start
//  adc_ready      in   1       1-cycle strobe from adc_module: adc_data valid
//  adc_data       in   12      sample from adc_module
//  adc_otr        in   1       ADC out-of-range flag, same timing as adc_data
//  adc_enable     out  1       enable to adc_module
//  wr_req         out  1       burst request; held until wr_ack
//  wr_addr        out  ADDR_W  burst start address; stable while wr_req=1
//  wr_ack         in   1       1-cycle grant from PSRAM controller
//  wr_data_valid  out  1       high for the BURST_WORDS beats of a burst
//  wr_data        out  16      burst data beat
//  busy           out  1       state != IDLE
//  done           out  1       1-cycle pulse at end of run
//  overflow       out  1       sticky: a sample was dropped; cleared at start
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; FIFO empty; counters 0.
//  FSM: IDLE -> WARMUP -> CAPTURE -> DRAIN -> DONE -> IDLE.
//  IDLE: start with num_bursts!=0: latch base_addr and num_bursts, clear overflow, adc_enable=1 next cycle, go WARMUP.
//   start with num_bursts==0: done pulses next cycle, state stays IDLE.
//  WARMUP: count and drop DISCARD adc_ready strobes, then go CAPTURE.
//  CAPTURE: each adc_ready pushes a word into the FIFO. Word = {3'b0, tag, adc_data}.
//   Capture ends after num_bursts*BURST_WORDS pushes: adc_enable=0 next cycle, go DRAIN.
//  Push to a full FIFO: sample dropped, not counted, overflow=1.
//  stop in WARMUP or CAPTURE: adc_enable=0 next cycle, go DRAIN.
//   The FIFO remainder below BURST_WORDS is discarded. Already complete bursts still flush.
//  Burst engine (runs in CAPTURE and DRAIN, one burst at a time):
//   Starts when fifo_count>=BURST_WORDS: wr_req=1 with wr_addr.
//   wr_ack seen while wr_req=1: wr_req=0 next cycle.
//   The next BURST_WORDS cycles have wr_data_valid=1, one FIFO pop per beat, no gaps.
//   After the last beat, wr_addr += BURST_WORDS (wraps modulo 2^ADDR_W).
//   wr_ack while wr_req=0 is ignored.
//  Push and pop in the same cycle: both take effect; count unchanged.
//  DRAIN: once no full burst remains and no burst is active, flush the FIFO and go DONE.
//  DONE: done=1 for one cycle, then IDLE (busy=0 in that same next cycle).
//  Reset mid-run: immediate return to reset state. An open burst is abandoned.
// CONFIGURATION
//  ADC_OTR_TAG_EN defined: tag=adc_otr (wr_data[12]) for each sample.
//  Not defined: tag=0 and adc_otr is ignored (port still present).
// STRUCTURE
//  Package acq_pkg: state enum (IDLE, WARMUP, CAPTURE, DRAIN, DONE), ACQ_WORD_W=16, sample-word pack function.
//  Sub-module acq_fifo: synchronous FIFO with count, full, empty, flush. Controller holds the FSM and burst engine.
// TESTING
//  Basic run: num_bursts=2, base=0x100, ready every 10 clk, data=0..: first 2 strobes dropped.
//   Bursts at 0x100 and 0x108 carry data 2..17. done pulses once; adc_enable=0 after 16 pushes.
//  Slow ack: wr_ack 40 cycles late, ready every 3 clk: FIFO fills, overflow=1.
//   Beats are contiguous; dropped samples are absent, not substituted.
//  Stop mid-run: stop after 13 captured words, BURST_WORDS=8: one burst written.
//   5 words discarded; done asserted; no further wr_req.
//  Edge cases: num_bursts=0 gives done only, adc_enable stays 0.
//   start while busy is ignored. Address wraps at 2^ADDR_W.
//  Reset asserted during a burst: every output returns to 0 in the next cycle. A following start runs cleanly.
//  Both builds: adc_otr=1 on sample 5 gives wr_data[12]=1 only with ADC_OTR_TAG_EN.

Source files
------------

// File: rtl/acq_pkg.sv
// acq_pkg: shared state encoding, word width and sample packing for the ADC acquisition path.
package acq_pkg;
  typedef enum logic [2:0] {IDLE, WARMUP, CAPTURE, DRAIN, DONE} state_e;
  localparam int ACQ_WORD_W = 16;
  function automatic logic [ACQ_WORD_W-1:0] pack_word(input logic tag, input logic [11:0] data);
    return {3'b000, tag, data};
  endfunction
endpackage

// File: rtl/adc_acq_controller_if.sv
// adc_acq_controller_if: control, ADC and PSRAM write-port signals of the acquisition controller.
interface adc_acq_controller_if #(parameter int ADDR_W = 21);
  logic start, stop, adc_ready, adc_otr, adc_enable;
  logic wr_req, wr_ack, wr_data_valid, busy, done, overflow;
  logic [ADDR_W-1:0] base_addr, wr_addr;
  logic [15:0] num_bursts, wr_data;
  logic [11:0] adc_data;
  modport master (
    input  start, stop, base_addr, num_bursts, adc_ready, adc_data, adc_otr, wr_ack,
    output adc_enable, wr_req, wr_addr, wr_data_valid, wr_data, busy, done, overflow
  );
  modport slave (
    output start, stop, base_addr, num_bursts, adc_ready, adc_data, adc_otr, wr_ack,
    input  adc_enable, wr_req, wr_addr, wr_data_valid, wr_data, busy, done, overflow
  );
endinterface

// File: rtl/acq_fifo.sv
// acq_fifo: synchronous sample FIFO with occupancy count and a flush that empties it in one cycle.
module acq_fifo #(
  parameter int W = 16,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic [AW:0]  count,
  output logic         full,
  output logic         empty
);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0] cnt_q;
  logic do_push, do_pop;
  assign full = cnt_q == (AW+1)'(DEPTH);
  assign empty = cnt_q == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign rdata = mem_q[rp_q];
  assign count = cnt_q;
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wp_q <= wp_q + AW'(1);
      if (do_pop) rp_q <= rp_q + AW'(1);
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wp_q] <= wdata;
  end
endmodule

// File: rtl/adc_acq_controller.sv
// adc_acq_controller: sequences one ADC capture run into fixed-length PSRAM write bursts.
// Define ADC_OTR_TAG_EN to carry adc_otr in bit 12 of each stored word.
module adc_acq_controller
  import acq_pkg::*;
#(
  parameter int BURST_WORDS = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_W = 21,
  parameter int DISCARD = 2
) (
  input logic clk_PSRAM,
  input logic rst_n,
  adc_acq_controller_if.master bus
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int BL = $clog2(BURST_WORDS);
  localparam int PW = 16 + BL;
  localparam int DW = $clog2(DISCARD + 1);
  localparam logic [CW-1:0] BWC = CW'(BURST_WORDS);
  localparam logic [BL:0] BWB = (BL+1)'(BURST_WORDS);
`ifdef ADC_OTR_TAG_EN
  localparam bit TAG_EN = 1'b1;
`else
  localparam bit TAG_EN = 1'b0;
`endif
  state_e state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0] nb_q, nb_d;
  logic [PW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] disc_q, disc_d;
  logic [BL:0] beat_q, beat_d;
  logic req_q, req_d, en_q, en_d, done_q, done_d, ovf_q, ovf_d;
  logic push, pop, flush, full, empty, valid;
  logic [CW-1:0] fcnt;
  logic [ACQ_WORD_W-1:0] rdata;
  acq_fifo #(.W(ACQ_WORD_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk_PSRAM), .rst_n(rst_n), .push(push), .pop(pop), .flush(flush),
    .wdata(pack_word(TAG_EN && bus.adc_otr, bus.adc_data)), .rdata(rdata),
    .count(fcnt), .full(full), .empty(empty)
  );
  assign valid = beat_q != '0;
  assign pop = valid && !empty;
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    nb_d = nb_q;
    cnt_d = cnt_q;
    disc_d = disc_q;
    beat_d = beat_q;
    req_d = req_q;
    en_d = en_q;
    done_d = 1'b0;
    ovf_d = ovf_q;
    push = 1'b0;
    flush = 1'b0;
    case (state_q)
      IDLE: if (bus.start) begin
        if (bus.num_bursts == '0) done_d = 1'b1;
        else begin
          state_d = WARMUP;
          addr_d = bus.base_addr;
          nb_d = bus.num_bursts;
          cnt_d = '0;
          disc_d = '0;
          ovf_d = 1'b0;
          en_d = 1'b1;
        end
      end
      WARMUP: if (bus.stop) begin
        state_d = DRAIN;
        en_d = 1'b0;
      end else if (bus.adc_ready) begin
        disc_d = disc_q + DW'(1);
        state_d = disc_q == DW'(DISCARD - 1) ? CAPTURE : WARMUP;
      end
      CAPTURE: begin
        push = bus.adc_ready && !full;
        ovf_d = ovf_q || (bus.adc_ready && full);
        cnt_d = push ? cnt_q + PW'(1) : cnt_q;
        if (bus.stop || (push && cnt_q + PW'(1) == {nb_q, BL'(0)})) begin
          state_d = DRAIN;
          en_d = 1'b0;
        end
      end
      // Only a partial burst can be left once the engine is idle; it is discarded.
      DRAIN: if (!req_q && !valid && fcnt < BWC) begin
        flush = 1'b1;
        state_d = DONE;
        done_d = 1'b1;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if ((state_q == CAPTURE || state_q == DRAIN) && !req_q && !valid && fcnt >= BWC) req_d = 1'b1;
    if (req_q && bus.wr_ack) begin
      req_d = 1'b0;
      beat_d = BWB;
    end
    if (valid) begin
      beat_d = beat_q - (BL+1)'(1);
      addr_d = beat_q == (BL+1)'(1) ? addr_q + ADDR_W'(BURST_WORDS) : addr_d;
    end
  end
  always_ff @(posedge clk_PSRAM) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q <= '0;
      nb_q <= '0;
      cnt_q <= '0;
      disc_q <= '0;
      beat_q <= '0;
      req_q <= 1'b0;
      en_q <= 1'b0;
      done_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      nb_q <= nb_d;
      cnt_q <= cnt_d;
      disc_q <= disc_d;
      beat_q <= beat_d;
      req_q <= req_d;
      en_q <= en_d;
      done_q <= done_d;
      ovf_q <= ovf_d;
    end
  end
  assign bus.adc_enable = en_q;
  assign bus.wr_req = req_q;
  assign bus.wr_addr = addr_q;
  assign bus.wr_data_valid = valid;
  assign bus.wr_data = valid ? rdata : '0;
  assign bus.busy = state_q != IDLE;
  assign bus.done = done_q;
  assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_adc_acq_controller.sv
// tb_adc_acq_controller: directed runs with a queue scoreboard checking burst addresses and beat data.
module tb_adc_acq_controller;
  localparam int AW = 21;
`ifdef ADC_OTR_TAG_EN
  localparam bit TAG = 1'b1;
`else
  localparam bit TAG = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int tests = 0, fails = 0;
  int ack_lat = 1, adc_period = 10, seq = 0, ph = 0, age = 0;
  int done_cnt = 0, req_rises = 0, beat_total = 0, run_len = 0;
  bit loose = 1'b0, req_prev = 1'b0;
  logic [15:0] last_w = '0;
  logic [15:0] exp_d[$];
  logic [AW-1:0] exp_a[$];

  adc_acq_controller_if #(.ADDR_W(AW)) bus();
  adc_acq_controller #(.BURST_WORDS(8), .FIFO_DEPTH(16), .ADDR_W(AW), .DISCARD(2)) dut (
    .clk_PSRAM(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic note_fail(input string name, input logic [31:0] act);
    tests++;
    fails++;
    $display("FAIL %s: unexpected value 0x%0h", name, act);
  endtask

  function automatic logic [15:0] word(input int v);
    return {3'b000, TAG && v == 5, 12'(v)};
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Expected addresses for `bursts` bursts; exact data only for the first `dbursts`.
  task automatic expect_run(input logic [AW-1:0] base, input int bursts, input int dbursts, input int first);
    for (int b = 0; b < bursts; b++) begin
      exp_a.push_back(base + AW'(8 * b));
      if (b < dbursts) for (int i = 0; i < 8; i++) exp_d.push_back(word(first + 8 * b + i));
    end
  endtask

  task automatic run(input logic [AW-1:0] base, input logic [15:0] nb);
    bus.base_addr = base;
    bus.num_bursts = nb;
    bus.start = 1'b1;
    cyc(1);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int d0, n;
    d0 = done_cnt;
    n = 0;
    while (done_cnt == d0 && n < budget) begin
      cyc(1);
      n++;
    end
    cyc(3);
    chk(name, 32'(done_cnt - d0), 32'd1);
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_ctrl"}, 32'({bus.adc_enable, bus.wr_req, bus.wr_data_valid, bus.busy, bus.done, bus.overflow}), 32'd0);
    chk({name, "_addr"}, 32'(bus.wr_addr), 32'd0);
    chk({name, "_data"}, 32'(bus.wr_data), 32'd0);
  endtask

  // adc_module model: one strobe every adc_period cycles while enabled, data counts up.
  initial begin
    bus.adc_ready = 1'b0;
    bus.adc_data = '0;
    bus.adc_otr = 1'b0;
    forever begin
      @(negedge clk);
      bus.adc_ready = 1'b0;
      bus.adc_otr = 1'b0;
      if (bus.adc_enable) begin
        if (ph >= adc_period - 1) begin
          bus.adc_ready = 1'b1;
          bus.adc_data = 12'(seq);
          bus.adc_otr = seq == 5;
          seq++;
          ph = 0;
        end else ph++;
      end else ph = 0;
    end
  end

  // PSRAM controller model: grant a request ack_lat cycles after it appears.
  initial begin
    bus.wr_ack = 1'b0;
    forever begin
      @(negedge clk);
      bus.wr_ack = 1'b0;
      if (bus.wr_req) begin
        if (age == ack_lat) begin
          if (exp_a.size() == 0) note_fail("wr_addr_extra", 32'(bus.wr_addr));
          else chk("wr_addr", 32'(bus.wr_addr), 32'(exp_a.pop_front()));
          bus.wr_ack = 1'b1;
        end
        age++;
      end else age = 0;
    end
  end

  initial forever begin
    @(negedge clk);
    if (bus.wr_data_valid) begin
      run_len++;
      beat_total++;
      if (exp_d.size() != 0) chk("wr_data", 32'(bus.wr_data), 32'(exp_d.pop_front()));
      else if (loose) chk("wr_data_order", 32'(bus.wr_data > last_w && 32'(bus.wr_data) < 32'(seq)), 32'd1);
      else note_fail("wr_data_extra", 32'(bus.wr_data));
      last_w = bus.wr_data;
    end else if (run_len != 0) begin
      chk("burst_len", 32'(run_len), 32'd8);
      run_len = 0;
    end
    if (bus.done) done_cnt++;
    if (bus.wr_req && !req_prev) req_rises++;
    req_prev = bus.wr_req;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.start = 1'b0;
    bus.stop = 1'b0;
    bus.base_addr = '0;
    bus.num_bursts = '0;
    cyc(3);
    chk_zero("reset");
    rst_n = 1'b1;
    cyc(1);

    // Basic run, with a start pulse while busy that must be ignored.
    ack_lat = 3; adc_period = 10; seq = 0;
    expect_run(21'h100, 2, 2, 2);
    run(21'h100, 16'd2);
    chk("basic_enable_on", 32'(bus.adc_enable), 32'd1);
    chk("basic_busy_on", 32'(bus.busy), 32'd1);
    cyc(30);
    run(21'h300, 16'd5);
    wait_done("basic_done_once", 1000);
    chk("basic_enable_off", 32'(bus.adc_enable), 32'd0);
    chk("basic_strobes", 32'(seq), 32'd18);
    chk("basic_busy_off", 32'(bus.busy), 32'd0);
    chk("basic_data_left", 32'(exp_d.size()), 32'd0);

    // Slow grants: FIFO fills and samples are dropped.
    ack_lat = 40; adc_period = 3; seq = 0; beat_total = 0; loose = 1'b1;
    expect_run(21'h400, 4, 2, 2);
    run(21'h400, 16'd4);
    wait_done("slow_done", 4000);
    chk("slow_overflow", 32'(bus.overflow), 32'd1);
    chk("slow_beats", 32'(beat_total), 32'd32);
    loose = 1'b0;

    // Stop after 13 captured words: one burst, 5 words discarded.
    ack_lat = 2; adc_period = 10; seq = 0; req_rises = 0;
    expect_run(21'h200, 1, 1, 2);
    run(21'h200, 16'd4);
    chk("stop_overflow_cleared", 32'(bus.overflow), 32'd0);
    n = 0;
    while (seq < 15 && n < 500) begin
      cyc(1);
      n++;
    end
    chk("stop_strobes_seen", 32'(seq), 32'd15);
    cyc(1);
    bus.stop = 1'b1;
    cyc(1);
    bus.stop = 1'b0;
    chk("stop_enable_off", 32'(bus.adc_enable), 32'd0);
    wait_done("stop_done", 500);
    cyc(20);
    chk("stop_one_burst", 32'(req_rises), 32'd1);
    chk("stop_data_left", 32'(exp_d.size()), 32'd0);

    // Zero-burst start: done only.
    run(21'h0, 16'd0);
    chk("zero_done", 32'(bus.done), 32'd1);
    chk("zero_enable", 32'(bus.adc_enable), 32'd0);
    chk("zero_busy", 32'(bus.busy), 32'd0);
    cyc(1);
    chk("zero_done_pulse", 32'(bus.done), 32'd0);

    // Address wrap at 2^21.
    ack_lat = 1; adc_period = 4; seq = 0;
    expect_run(21'h1FFFF8, 2, 2, 2);
    run(21'h1FFFF8, 16'd2);
    wait_done("wrap_done", 1000);
    chk("wrap_addr_left", 32'(exp_a.size()), 32'd0);

    // Reset while a burst request is pending, then a clean run.
    ack_lat = 1000; adc_period = 2; seq = 0;
    expect_run(21'h080, 1, 1, 2);
    run(21'h080, 16'd1);
    n = 0;
    while (!bus.wr_req && n < 200) begin
      cyc(1);
      n++;
    end
    chk("rst_req_seen", 32'(bus.wr_req), 32'd1);
    rst_n = 1'b0;
    cyc(1);
    chk_zero("rst_mid");
    cyc(2);
    exp_d.delete();
    exp_a.delete();
    rst_n = 1'b1;
    ack_lat = 1; seq = 0;
    cyc(1);
    expect_run(21'h040, 1, 1, 2);
    run(21'h040, 16'd1);
    wait_done("post_rst_done", 500);
    chk("post_rst_data_left", 32'(exp_d.size()), 32'd0);
    chk("post_rst_addr_left", 32'(exp_a.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
